// File: rtl/shift_rotate_seq.sv
// shift_rotate_seq: sequential N-bit rotate/shift unit, one bit position per clock.
// An accepted START captures DIN/AMT/DIR/MODE. The unit then spends AMT cycles in SHIFT.
// It reports completion with a one-cycle DONE in FIN.
// Optional feature macro: SHIFT_ROTATE_CARRY_EN. When it is defined, the CARRY output
// holds the last bit shifted or rotated out of the working register.
module shift_rotate_seq #(
   parameter int N  = 8,
   parameter int AW = $clog2(N)
) (
   input  logic          CLK,
   input  logic          N_RESET,
   input  logic          START,
   input  logic [N-1:0]  DIN,
   input  logic [AW-1:0] AMT,
   input  logic          DIR,
   input  logic [1:0]    MODE,
   output logic          BUSY,
   output logic          DONE,
   output logic [N-1:0]  DOUT
`ifdef SHIFT_ROTATE_CARRY_EN
   ,
   output logic          CARRY
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_FIN   = 2'b10;

   localparam logic [1:0] MODE_ROT = 2'b00;
   localparam logic [1:0] MODE_LSH = 2'b01;
   localparam logic [1:0] MODE_ASH = 2'b10;

   localparam logic [AW-1:0] CNT_ZERO = '0;
   localparam logic [AW-1:0] CNT_ONE  = AW'(1);

   // One 1-bit step: returns {bit_shifted_out, new_word}.
   // MODE 11 is treated as a rotate. An arithmetic left shift is identical to a logical left shift.
   function automatic logic [N:0] step_f(input logic [N-1:0] r,
                                         input logic         dir,
                                         input logic [1:0]   mode);
      logic [N:0] res;
      res = {1'b0, r};
      if (dir) begin
         case (mode)
            MODE_LSH: res = {r[0], 1'b0,   r[N-1:1]};
            MODE_ASH: res = {r[0], r[N-1], r[N-1:1]};
            default:  res = {r[0], r[0],   r[N-1:1]};
         endcase
      end else begin
         case (mode)
            MODE_LSH: res = {r[N-1], r[N-2:0], 1'b0};
            MODE_ASH: res = {r[N-1], r[N-2:0], 1'b0};
            default:  res = {r[N-1], r[N-2:0], r[N-1]};
         endcase
      end
      return res;
   endfunction

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  data_q,  data_d;
   logic [AW-1:0] cnt_q,   cnt_d;
   logic          dir_q,   dir_d;
   logic [1:0]    mode_q,  mode_d;
   logic          carry_q, carry_d;
   logic [N:0]    step_s;

   assign step_s = step_f(data_q, dir_q, mode_q);

   // Next-state and datapath update for the IDLE/SHIFT/FIN sequence.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      carry_d = carry_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               data_d  = DIN;
               cnt_d   = AMT;
               dir_d   = DIR;
               mode_d  = MODE;
               carry_d = 1'b0;
               if (AMT != CNT_ZERO) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_FIN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            data_d  = step_s[N-1:0];
            carry_d = step_s[N];
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = ST_FIN;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!N_RESET) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 2'b00;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         carry_q <= carry_d;
      end
   end

   assign BUSY = (state_q != ST_IDLE);
   assign DONE = (state_q == ST_FIN);
   assign DOUT = data_q;

`ifdef SHIFT_ROTATE_CARRY_EN
   assign CARRY = carry_q;
`else
   logic unused_carry_s;
   assign unused_carry_s = carry_q;
`endif

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed, table-driven bench for shift_rotate_seq (N=8).
module tb_shift_rotate_seq;

   localparam int N  = 8;
   localparam int AW = 3;

   logic          CLK;
   logic          N_RESET;
   logic          START;
   logic [N-1:0]  DIN;
   logic [AW-1:0] AMT;
   logic          DIR;
   logic [1:0]    MODE;
   logic          BUSY;
   logic          DONE;
   logic [N-1:0]  DOUT;
`ifdef SHIFT_ROTATE_CARRY_EN
   logic          CARRY;
`endif

   shift_rotate_seq #(.N(N), .AW(AW)) dut (
      .CLK     (CLK),
      .N_RESET (N_RESET),
      .START   (START),
      .DIN     (DIN),
      .AMT     (AMT),
      .DIR     (DIR),
      .MODE    (MODE),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .DOUT    (DOUT)
`ifdef SHIFT_ROTATE_CARRY_EN
      ,
      .CARRY   (CARRY)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] din;
      logic [2:0] amt;
      logic       dir;
      logic [1:0] mode;
      logic [7:0] exp_dout;
      logic       exp_carry;
   } vec_t;

   vec_t vecs [10];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Launch one operation, then watch it to completion.
   // Reports the result, DONE latency in cycles after the START edge, BUSY cycles and DONE pulses.
   task automatic run_op(input logic [7:0] din, input logic [2:0] amt, input logic dir,
                         input logic [1:0] mode, input int inject_at,
                         output logic [7:0] res, output logic cy,
                         output int lat, output int busy_cnt, output int done_cnt);
      @(negedge CLK);
      DIN = din; AMT = amt; DIR = dir; MODE = mode; START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      DIN = ~din; AMT = ~amt; DIR = ~dir; MODE = ~mode;
      lat = -1; busy_cnt = 0; done_cnt = 0; res = '0; cy = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (c == inject_at) begin
            START = 1'b1; DIN = 8'hFF; AMT = 3'd1;
         end else begin
            START = 1'b0;
         end
         if (BUSY) busy_cnt++;
         if (DONE) begin
            done_cnt++;
            if (lat < 0) begin
               lat = c;
               res = DOUT;
`ifdef SHIFT_ROTATE_CARRY_EN
               cy = CARRY;
`endif
            end
         end
         if (!BUSY && lat >= 0) break;
      end
      START = 1'b0;
   endtask

   initial begin
      logic [7:0] res, cur, exp;
      logic       cy;
      int lat, bc, dc;

      vecs[0] = '{8'hAC, 3'd3, 1'b1, 2'b00, 8'h95, 1'b1};
      vecs[1] = '{8'hAC, 3'd3, 1'b0, 2'b00, 8'h65, 1'b1};
      vecs[2] = '{8'hAC, 3'd2, 1'b1, 2'b01, 8'h2B, 1'b0};
      vecs[3] = '{8'hAC, 3'd2, 1'b1, 2'b10, 8'hEB, 1'b0};
      vecs[4] = '{8'hAC, 3'd3, 1'b0, 2'b01, 8'h60, 1'b1};
      vecs[5] = '{8'hAC, 3'd0, 1'b1, 2'b00, 8'hAC, 1'b0};
      vecs[6] = '{8'hAC, 3'd1, 1'b1, 2'b11, 8'h56, 1'b0};
      vecs[7] = '{8'hAC, 3'd1, 1'b0, 2'b10, 8'h58, 1'b1};
      vecs[8] = '{8'h81, 3'd7, 1'b1, 2'b00, 8'h03, 1'b0};
      vecs[9] = '{8'h2C, 3'd7, 1'b1, 2'b10, 8'h00, 1'b0};

      N_RESET = 1'b0; START = 1'b0; DIN = '0; AMT = '0; DIR = 1'b0; MODE = 2'b00;
      repeat (3) @(posedge CLK);
      #1 N_RESET = 1'b1;
      @(negedge CLK);
      chk("reset_busy", {31'd0, BUSY}, 32'd0);
      chk("reset_done", {31'd0, DONE}, 32'd0);
      chk("reset_dout", {24'd0, DOUT}, 32'd0);
`ifdef SHIFT_ROTATE_CARRY_EN
      chk("reset_carry", {31'd0, CARRY}, 32'd0);
`endif

      // table of single operations
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].din, vecs[i].amt, vecs[i].dir, vecs[i].mode, -1, res, cy, lat, bc, dc);
         chk($sformatf("v%0d_dout", i), {24'd0, res}, {24'd0, vecs[i].exp_dout});
         chk($sformatf("v%0d_lat", i), lat, {29'd0, vecs[i].amt});
         chk($sformatf("v%0d_busy", i), bc, {29'd0, vecs[i].amt} + 32'd1);
         chk($sformatf("v%0d_done", i), dc, 32'd1);
         chk($sformatf("v%0d_hold", i), {24'd0, DOUT}, {24'd0, vecs[i].exp_dout});
`ifdef SHIFT_ROTATE_CARRY_EN
         chk($sformatf("v%0d_carry", i), {31'd0, cy}, {31'd0, vecs[i].exp_carry});
         chk($sformatf("v%0d_carry_hold", i), {31'd0, CARRY}, {31'd0, vecs[i].exp_carry});
`endif
      end

      // eight chained single-step right rotates
      cur = 8'hAC;
      for (int i = 0; i < 8; i++) begin
         exp = {cur[0], cur[7:1]};
         run_op(cur, 3'd1, 1'b1, 2'b00, -1, res, cy, lat, bc, dc);
         chk($sformatf("chain%0d", i), {24'd0, res}, {24'd0, exp});
         cur = res;
      end
      chk("chain_wrap", {24'd0, cur}, 32'h0000_00AC);

      // START pulsed during an in-flight AMT=5 rotate is ignored
      run_op(8'hAC, 3'd5, 1'b1, 2'b00, 2, res, cy, lat, bc, dc);
      chk("ign_dout", {24'd0, res}, 32'h0000_0065);
      chk("ign_lat", lat, 32'd5);
      chk("ign_done", dc, 32'd1);
      chk("ign_idle", {31'd0, BUSY}, 32'd0);

      // reset asserted for one edge in mid-SHIFT
      @(negedge CLK);
      DIN = 8'hAC; AMT = 3'd5; DIR = 1'b1; MODE = 2'b00; START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("mid_busy", {31'd0, BUSY}, 32'd1);
      N_RESET = 1'b0;
      @(posedge CLK);
      #1 N_RESET = 1'b1;
      @(negedge CLK);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_done", {31'd0, DONE}, 32'd0);
      chk("rst_dout", {24'd0, DOUT}, 32'd0);
      repeat (6) begin
         @(negedge CLK);
         chk("rst_nodone", {31'd0, DONE}, 32'd0);
      end
      run_op(8'hAC, 3'd3, 1'b0, 2'b00, -1, res, cy, lat, bc, dc);
      chk("post_dout", {24'd0, res}, 32'h0000_0065);
      chk("post_lat", lat, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
